prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: MAX_WORDS, 256, largest accepted program length in 32-bit words.
REQ-002 Parameter: BASE_ADDR, 32'h0000_0000, byte address of the first instruction written.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle request to begin a load.
REQ-006 Port: in_valid  input  1  byte-stream valid.
REQ-007 Port: in_data  input  8  byte-stream data.
REQ-008 Port: in_ready  output  1  byte-stream ready.
REQ-009 Port: imem_we  output  1  instruction-memory write strobe.
REQ-010 Port: imem_addr  output  32  instruction-memory byte address, word-aligned.
REQ-011 Port: imem_wdata  output  32  instruction word to write.
REQ-012 Port: core_rst  output  1  reset to the single-cycle core; high while no valid program is loaded.
REQ-013 Port: busy / done / error  output  1 each  loader status flags.
REQ-014 Port: words_loaded  output  16  count of instruction words written this load.

Function
REQ-015 A byte is accepted only when in_valid and in_ready are both 1 on a rising edge.
REQ-016 Bytes pack big-endian: the first byte of each group of four goes to bits [31:24].
REQ-017 FSM states: IDLE, HDR, LOAD, CHK, DONE, ERR.
REQ-018 IDLE -> HDR on start; in HDR, 4 bytes form the length word N.
REQ-019 HDR -> ERR if N > MAX_WORDS; -> LOAD if 1 <= N <= MAX_WORDS; on N == 0 -> DONE, or -> CHK when checksum is enabled.
REQ-020 LOAD: each completed word drives imem_we=1 for exactly one cycle, in the cycle after its 4th byte is accepted, with imem_addr = BASE_ADDR + 4*words_loaded (pre-increment value).
REQ-021 words_loaded increments in the same cycle imem_we is 1; LOAD exits after the Nth write.
REQ-022 in_ready = 1 only in HDR, LOAD and CHK, and 0 during the imem_we cycle (no byte accepted while writing).
REQ-023 busy = 1 in HDR, LOAD and CHK; done = 1 only in DONE; error = 1 only in ERR.
REQ-024 core_rst = 1 in every state except DONE; it deasserts on the cycle DONE is entered.
REQ-025 start is ignored in HDR, LOAD and CHK; in DONE or ERR it re-enters HDR, clears words_loaded and reasserts core_rst in that cycle.
REQ-026 imem_addr wraps modulo 2^32 with no error.
REQ-027 Gaps in in_valid stall assembly indefinitely; there is no timeout.

Reset
REQ-028 Asynchronous assertion of rst forces IDLE, clears any partial byte and word counters, and drives these values: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_rst=1, busy=0, done=0, error=0, words_loaded=0.
REQ-029 Reset during LOAD abandons the load; words already written are not rolled back.

Configuration
REQ-030 Macro: PROG_LOADER_CHECKSUM_EN.
- Defined: after the Nth word, CHK accepts one 4-byte word; it is compared with the XOR of all N words, then -> DONE on match, -> ERR on mismatch.
- Undefined: the CHK state is absent, and LOAD or N == 0 goes directly to DONE.

Structure
REQ-031 Package mips_pkg holds the loader state enum, the MAX_WORDS default and the word/byte width constants.
REQ-032 The byte-to-word packer is the sub-module byte_packer: 2-bit byte counter, 32-bit shift register, word_valid pulse.

Verification
REQ-033 Length N=2, words 32'h2008_0005, 32'h0000_0000 -> writes to addresses 0x0 and 0x4, words_loaded=2, done=1, core_rst falls.
REQ-034 N=MAX_WORDS+1 -> ERR, error=1, core_rst=1, no imem_we pulse.
REQ-035 Checksum build, N=1, word 32'hAABB_CCDD, checksum 32'hAABB_CCDE -> ERR; with checksum 32'hAABB_CCDD -> DONE.
REQ-036 in_valid toggled every other cycle across N=3 -> same three writes as continuous stream; no byte accepted in an imem_we cycle.
REQ-037 rst pulsed after 6 bytes of N=4 load -> IDLE, all outputs at reset values; a new start then loads from BASE_ADDR cleanly.
REQ-038 start asserted mid-LOAD -> ignored; start in DONE -> core_rst=1 next cycle, words_loaded=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// default program-length limit and byte/word widths.
package mips_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned BYTES_PER_W   = WORD_W / BYTE_W;
  localparam int unsigned MAX_WORDS_DEF = 256;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: assembles accepted bytes big-endian into 32-bit words and
// pulses word_valid for one cycle after the fourth byte of each word.
module byte_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_out
);

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic              wv_q, wv_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    wv_d  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (byte_en) begin
      // Shifting left puts the first byte of a group in bits [31:24].
      sr_d  = {sr_q[WORD_W-BYTE_W-1:0], byte_in};
      cnt_d = cnt_q + 2'd1;
      wv_d  = (cnt_q == 2'd3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
      wv_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
      wv_q  <= wv_d;
    end
  end

  assign word_valid = wv_q;
  assign word_out   = sr_q;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: header length word, N instruction words written
// to imem, optional trailing XOR checksum (define PROG_LOADER_CHECKSUM_EN).
module prog_loader
  import mips_pkg::*;
#(
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  loader_state_t state_q, state_d;
  logic [31:0]   len_q, len_d;
  logic [15:0]   wl_q, wl_d;
  logic [31:0]   addr_q, addr_d;
  logic          pk_clr;
  logic          word_valid;
  logic [31:0]   word;
  logic          accept;
  logic [31:0]   wl_next;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam loader_state_t FIN_ST = ST_CHK;
  logic [31:0] xor_q, xor_d;
`else
  localparam loader_state_t FIN_ST = ST_DONE;
`endif

  assign busy     = (state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_CHK);
  assign done     = (state_q == ST_DONE);
  assign error    = (state_q == ST_ERR);
  assign core_rst = (state_q != ST_DONE);
  // Stream is held off while a completed word is being consumed.
  assign in_ready = busy && !word_valid;
  assign accept   = in_valid && in_ready;
  assign wl_next  = {16'h0000, wl_q} + 32'd1;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .byte_en    (accept),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word_out   (word)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wl_d    = wl_q;
    addr_d  = addr_q;
    pk_clr  = 1'b0;
    imem_we = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_HDR;
          wl_d    = '0;
          addr_d  = BASE_ADDR;
          pk_clr  = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      ST_HDR: begin
        if (word_valid) begin
          len_d = word;
          if (word > MAX_WORDS)
            state_d = ST_ERR;
          else if (word == 32'd0)
            state_d = FIN_ST;
          else
            state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (word_valid) begin
          imem_we = 1'b1;
          wl_d    = wl_q + 16'd1;
          addr_d  = addr_q + 32'd4;
`ifdef PROG_LOADER_CHECKSUM_EN
          xor_d   = xor_q ^ word;
`endif
          if (wl_next == len_q)
            state_d = FIN_ST;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (word_valid)
          state_d = (word == xor_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      wl_q    <= '0;
      addr_q  <= BASE_ADDR;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wl_q    <= wl_d;
      addr_q  <= addr_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign imem_addr    = addr_q;
  assign imem_wdata   = word;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader with hand-computed expectations.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, imem_we, core_rst, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] words_loaded;

  int total = 0;
  int bad   = 0;

  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_n    = 0;
  int          overlap = 0;

  prog_loader #(.MAX_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst     (core_rst),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = imem_addr;
        wr_data[wr_n] = imem_wdata;
      end
      wr_n++;
      if (in_ready !== 1'b0) overlap++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      in_valid = 1'b0;
      tick(1);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $error("FAIL byte_timeout: observed=in_ready_low expected=accept");
    end else begin
      tick(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    logic [31:0] t;
    t = w;
    send_byte(t[31:24], gap);
    send_byte(t[23:16], gap);
    send_byte(t[15:8],  gap);
    send_byte(t[7:0],   gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
    chk({tag, "_we"},    {31'b0, imem_we},  32'd0);
    chk({tag, "_addr"},  imem_addr,         32'h0);
    chk({tag, "_wdata"}, imem_wdata,        32'h0);
    chk({tag, "_crst"},  {31'b0, core_rst}, 32'd1);
    chk({tag, "_busy"},  {31'b0, busy},     32'd0);
    chk({tag, "_done"},  {31'b0, done},     32'd0);
    chk({tag, "_err"},   {31'b0, error},    32'd0);
    chk({tag, "_wl"},    {16'b0, words_loaded}, 32'd0);
  endtask

  initial begin
    int w0;

    // Reset state
    tick(2);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;
    tick(1);

    // N=2 continuous load
    w0 = wr_n;
    pulse_start();
    chk("hdr_busy", {31'b0, busy}, 32'd1);
    chk("hdr_ready", {31'b0, in_ready}, 32'd1);
    send_word(32'd2, 1'b0);
    send_word(32'h2008_0005, 1'b0);
    send_word(32'h0000_0000, 1'b0);
    tick(2);
    chk("n2_writes", wr_n - w0, 32'd2);
    chk("n2_a0", wr_addr[w0],   32'h0);
    chk("n2_d0", wr_data[w0],   32'h2008_0005);
    chk("n2_a1", wr_addr[w0+1], 32'h4);
    chk("n2_d1", wr_data[w0+1], 32'h0000_0000);
    chk("n2_wl", {16'b0, words_loaded}, 32'd2);
    chk("n2_done", {31'b0, done}, 32'd1);
    chk("n2_crst", {31'b0, core_rst}, 32'd0);
    chk("n2_busy", {31'b0, busy}, 32'd0);

    // start in DONE re-enters HDR
    pulse_start();
    chk("restart_crst", {31'b0, core_rst}, 32'd1);
    chk("restart_wl", {16'b0, words_loaded}, 32'd0);
    chk("restart_busy", {31'b0, busy}, 32'd1);

    // N=3 continuous with a start pulse mid-LOAD
    w0 = wr_n;
    send_word(32'd3, 1'b0);
    send_word(32'h1122_3344, 1'b0);
    tick(1);
    pulse_start();
    chk("midstart_busy", {31'b0, busy}, 32'd1);
    chk("midstart_wl", {16'b0, words_loaded}, 32'd1);
    send_word(32'h5566_7788, 1'b0);
    send_word(32'h99AA_BBCC, 1'b0);
    tick(2);
    chk("c3_writes", wr_n - w0, 32'd3);
    chk("c3_a2", wr_addr[w0+2], 32'h8);
    chk("c3_d2", wr_data[w0+2], 32'h99AA_BBCC);
    chk("c3_done", {31'b0, done}, 32'd1);

    // N = MAX_WORDS+1 -> ERR
    pulse_start();
    w0 = wr_n;
    send_word(32'd257, 1'b0);
    tick(2);
    chk("big_err", {31'b0, error}, 32'd1);
    chk("big_crst", {31'b0, core_rst}, 32'd1);
    chk("big_busy", {31'b0, busy}, 32'd0);
    chk("big_ready", {31'b0, in_ready}, 32'd0);
    chk("big_writes", wr_n - w0, 32'd0);

    // N=3 with in_valid toggling every other cycle, started from ERR
    pulse_start();
    chk("gap_err_clr", {31'b0, error}, 32'd0);
    w0 = wr_n;
    send_word(32'd3, 1'b1);
    send_word(32'h1122_3344, 1'b1);
    send_word(32'h5566_7788, 1'b1);
    send_word(32'h99AA_BBCC, 1'b1);
    tick(2);
    chk("gap_writes", wr_n - w0, 32'd3);
    chk("gap_a0", wr_addr[w0],   32'h0);
    chk("gap_d0", wr_data[w0],   32'h1122_3344);
    chk("gap_a1", wr_addr[w0+1], 32'h4);
    chk("gap_d1", wr_data[w0+1], 32'h5566_7788);
    chk("gap_a2", wr_addr[w0+2], 32'h8);
    chk("gap_d2", wr_data[w0+2], 32'h99AA_BBCC);
    chk("gap_done", {31'b0, done}, 32'd1);
    chk("gap_wl", {16'b0, words_loaded}, 32'd3);

    // Reset after 6 bytes of an N=4 load
    pulse_start();
    send_word(32'd4, 1'b0);
    send_byte(8'hCA, 1'b0);
    send_byte(8'hFE, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick(1);
    rst = 1'b0;
    tick(1);
    w0 = wr_n;
    pulse_start();
    send_word(32'd1, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(32'hDEAD_BEEF, 1'b0);
`endif
    tick(2);
    chk("post_writes", wr_n - w0, 32'd1);
    chk("post_a0", wr_addr[w0], 32'h0);
    chk("post_d0", wr_data[w0], 32'hDEAD_BEEF);
    chk("post_done", {31'b0, done}, 32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
    pulse_start();
    send_word(32'd1, 1'b0);
    send_word(32'hAABB_CCDD, 1'b0);
    send_word(32'hAABB_CCDE, 1'b0);
    tick(2);
    chk("cs_bad_err", {31'b0, error}, 32'd1);
    pulse_start();
    send_word(32'd1, 1'b0);
    send_word(32'hAABB_CCDD, 1'b0);
    send_word(32'hAABB_CCDD, 1'b0);
    tick(2);
    chk("cs_ok_done", {31'b0, done}, 32'd1);
`else
    pulse_start();
    w0 = wr_n;
    send_word(32'd0, 1'b0);
    tick(2);
    chk("n0_done", {31'b0, done}, 32'd1);
    chk("n0_writes", wr_n - w0, 32'd0);
    chk("n0_wl", {16'b0, words_loaded}, 32'd0);
`endif

    chk("no_accept_in_we", overlap, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
